// File: rtl/abstract_cmd_ctrl_if.sv
// Handshake bundle between the DMI register file, the access-register decoder,
// the halted hart's fetch path and the abstract command sequencer.
interface abstract_cmd_ctrl_if;
  logic        cmd_wr_en;
  logic [7:0]  cmd_cmdtype;
  logic        cmd_transfer;
  logic        cmd_write;
  logic        cmd_postexec;
  logic [2:0]  cmd_aarsize;
  logic [15:0] cmd_regno;
  logic [2:0]  cmderr_clr;
  logic        hart_halted;

  logic [7:0]  q_cmdtype;
  logic        q_transfer;
  logic        q_write;
  logic [2:0]  q_aarsize;
  logic [15:0] q_regno;

  logic [31:0] dec_inst0;
  logic [31:0] dec_inst1;
  logic        dec_size_err;

  logic [1:0]  absbuf_idx;
  logic [31:0] absbuf_rdata;

  logic        hart_go;
  logic        hart_going;
  logic        hart_done;
  logic        hart_exception;

  logic        busy;
  logic [2:0]  cmderr;

  modport master (
    output cmd_wr_en, cmd_cmdtype, cmd_transfer, cmd_write, cmd_postexec,
           cmd_aarsize, cmd_regno, cmderr_clr, hart_halted,
           dec_inst0, dec_inst1, dec_size_err, absbuf_idx,
           hart_going, hart_done, hart_exception,
    input  q_cmdtype, q_transfer, q_write, q_aarsize, q_regno,
           absbuf_rdata, hart_go, busy, cmderr
  );

  modport slave (
    input  cmd_wr_en, cmd_cmdtype, cmd_transfer, cmd_write, cmd_postexec,
           cmd_aarsize, cmd_regno, cmderr_clr, hart_halted,
           dec_inst0, dec_inst1, dec_size_err, absbuf_idx,
           hart_going, hart_done, hart_exception,
    output q_cmdtype, q_transfer, q_write, q_aarsize, q_regno,
           absbuf_rdata, hart_go, busy, cmderr
  );
endinterface

// File: rtl/abstract_cmd_ctrl.sv
// Abstract command sequencer: latches a DMI command, validates it, serves the
// 4-entry abstract buffer to the hart and tracks go/going/done/exception.
module abstract_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                 clk,
  input logic                 rst,
  abstract_cmd_ctrl_if.slave  bus
);

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] PROGBUF_JAL = 32'h7fd0_706f;
  localparam int          WD_W        = $clog2(TIMEOUT_CYC + 2);

  localparam logic [2:0] ERR_BUSY      = 3'd1;
  localparam logic [2:0] ERR_NOT_SUPP  = 3'd2;
  localparam logic [2:0] ERR_EXCEPTION = 3'd3;
  localparam logic [2:0] ERR_HALT      = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd7;

  typedef enum logic [1:0] {IDLE, CHECK, GO, EXEC} state_t;

  state_t          state, state_nxt;
  logic [7:0]      q_cmdtype;
  logic            q_transfer;
  logic            q_write;
  logic [2:0]      q_aarsize;
  logic [15:0]     q_regno;
  logic            postexec_q;
  logic [2:0]      cmderr;
  logic [WD_W-1:0] wdog_cnt;

  logic            accept;
  logic            err_set;
  logic [2:0]      err_code;
  logic            running;
  logic            wdog_expire;
  logic            wr_while_busy;

  assign running       = (state == GO) || (state == EXEC);
  assign wdog_expire   = (TIMEOUT_CYC != 0) && running &&
                         (wdog_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign wr_while_busy = bus.cmd_wr_en && (state != IDLE);

  // NOTE: every output of this block gets a default before the case, otherwise
  // a path that forgets one of them infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_set   = 1'b0;
    err_code  = 3'd0;
    case (state)
      IDLE: begin
        if (bus.cmd_wr_en && (cmderr == 3'd0)) begin
          accept    = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (q_cmdtype != 8'd0) begin
          err_set = 1'b1; err_code = ERR_NOT_SUPP; state_nxt = IDLE;
        end else if (q_transfer && (bus.dec_size_err || (q_regno[15:12] > 4'd1))) begin
          err_set = 1'b1; err_code = ERR_NOT_SUPP; state_nxt = IDLE;
        end else if (!bus.hart_halted) begin
          err_set = 1'b1; err_code = ERR_HALT; state_nxt = IDLE;
        end else if (!q_transfer && !postexec_q) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = GO;
        end
      end
      GO: begin
        if (wdog_expire) begin
          err_set = 1'b1; err_code = ERR_TIMEOUT; state_nxt = IDLE;
        end else if (bus.hart_going) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // A done in the expiry cycle beats the watchdog.
        if (bus.hart_exception) begin
          err_set = 1'b1; err_code = ERR_EXCEPTION; state_nxt = IDLE;
        end else if (bus.hart_done) begin
          state_nxt = IDLE;
        end else if (wdog_expire) begin
          err_set = 1'b1; err_code = ERR_TIMEOUT; state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q_cmdtype  <= '0;
      q_transfer <= 1'b0;
      q_write    <= 1'b0;
      q_aarsize  <= '0;
      q_regno    <= '0;
      postexec_q <= 1'b0;
      cmderr     <= '0;
      wdog_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        q_cmdtype  <= bus.cmd_cmdtype;
        q_transfer <= bus.cmd_transfer;
        q_write    <= bus.cmd_write;
        q_aarsize  <= bus.cmd_aarsize;
        q_regno    <= bus.cmd_regno;
        postexec_q <= bus.cmd_postexec;
        wdog_cnt   <= '0;
      end else if (running) begin
        wdog_cnt <= wdog_cnt + WD_W'(1);
      end
      // Only a zero cmderr may take a new code, so the first error sticks.
      if ((cmderr == 3'd0) && err_set)
        cmderr <= err_code;
      else if ((cmderr == 3'd0) && wr_while_busy)
        cmderr <= ERR_BUSY;
      else
        cmderr <= cmderr & ~bus.cmderr_clr;
    end
  end

  always_comb begin
    bus.absbuf_rdata = EBREAK_INST;
    case (bus.absbuf_idx)
      2'd0:    bus.absbuf_rdata = q_transfer ? bus.dec_inst0 : NOP_INST;
      2'd1:    bus.absbuf_rdata = q_transfer ? bus.dec_inst1 : NOP_INST;
      2'd2:    bus.absbuf_rdata = postexec_q ? PROGBUF_JAL : EBREAK_INST;
      default: bus.absbuf_rdata = EBREAK_INST;
    endcase
  end

  assign bus.q_cmdtype  = q_cmdtype;
  assign bus.q_transfer = q_transfer;
  assign bus.q_write    = q_write;
  assign bus.q_aarsize  = q_aarsize;
  assign bus.q_regno    = q_regno;
  assign bus.busy       = (state != IDLE);
  assign bus.hart_go    = (state == GO);
  assign bus.cmderr     = cmderr;

endmodule

// File: tb/tb_abstract_cmd_ctrl.sv
// Self-checking bench for abstract_cmd_ctrl: directed vector table, hand-written
// corner sequences and randomized commands against a cycle-count outcome model.
module tb_abstract_cmd_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JAL    = 32'h7fd0_706f;
  localparam int          TMO    = 16;
  localparam int          WIN    = 26;

  typedef struct {
    logic [7:0]  cmdtype;
    logic        transfer;
    logic        write;
    logic        postexec;
    logic [2:0]  aarsize;
    logic [15:0] regno;
    logic        halted;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          d_go;
    int          d_done;
    bit          exc;
    int          e_err;
    int          e_busy;
    int          e_go;
    bit          lit;
    logic [31:0] i0, i1, i2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  abstract_cmd_ctrl_if bus ();

  abstract_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference access-register decoder: data0 sits at 0x400, s0 is the scratch.
  function automatic logic [31:0] dec_inst(input logic wr, input logic [15:0] regno, input int slot);
    logic [4:0] r;
    r = regno[4:0];
    if (regno[15:12] == 4'h1) begin
      if (slot == 1) return NOP;
      return wr ? {12'h400, 5'd0, 3'b010, r, 7'b0000011}
                : {7'h20, r, 5'd0, 3'b010, 5'd0, 7'b0100011};
    end else if (regno[15:12] == 4'h0) begin
      if (wr)
        return (slot == 0) ? {12'h400, 5'd0, 3'b010, 5'd8, 7'b0000011}
                           : {regno[11:0], 5'd8, 3'b001, 5'd0, 7'b1110011};
      return (slot == 0) ? {regno[11:0], 5'd0, 3'b010, 5'd8, 7'b1110011}
                         : {7'h20, 5'd8, 5'd0, 3'b010, 5'd0, 7'b0100011};
    end
    return NOP;
  endfunction

  always_comb begin
    bus.dec_inst0    = dec_inst(bus.q_write, bus.q_regno, 0);
    bus.dec_inst1    = dec_inst(bus.q_write, bus.q_regno, 1);
    bus.dec_size_err = (bus.q_aarsize != 3'd2);
  end

  function automatic logic [31:0] exp_buf(input cmd_t c, input int idx);
    case (idx)
      0:       return c.transfer ? dec_inst(c.write, c.regno, 0) : NOP;
      1:       return c.transfer ? dec_inst(c.write, c.regno, 1) : NOP;
      2:       return c.postexec ? JAL : EBREAK;
      default: return EBREAK;
    endcase
  endfunction

  // Outcome of a whole command from its fields and the hart's response delays.
  function automatic void model(input cmd_t c, input int d_go, input int d_done, input bit exc,
                                output int e_err, output int e_busy, output int e_go);
    int t;
    e_err = 0; e_busy = 1; e_go = 0;
    if (c.cmdtype != 0)                                         e_err = 2;
    else if (c.transfer && (c.aarsize != 3'd2 || c.regno[15:12] > 1)) e_err = 2;
    else if (!c.halted)                                         e_err = 4;
    else if (c.transfer || c.postexec) begin
      t = d_go + d_done + 2;
      if (t <= TMO) begin
        e_err  = exc ? 3 : 0;
        e_busy = 1 + t;
        e_go   = d_go + 1;
      end else begin
        e_err  = 7;
        e_busy = 1 + TMO;
        e_go   = (d_go + 1 < TMO) ? d_go + 1 : TMO;
      end
    end
  endfunction

  function automatic vec_t mk(input logic [7:0] ty, input logic tr, input logic wr, input logic pe,
                              input logic [2:0] sz, input logic [15:0] rn, input logic h,
                              input int dg, input int dd, input bit ex,
                              input int ee, input int eb, input int eg);
    vec_t v;
    v.c.cmdtype = ty; v.c.transfer = tr; v.c.write = wr; v.c.postexec = pe;
    v.c.aarsize = sz; v.c.regno = rn; v.c.halted = h;
    v.d_go = dg; v.d_done = dd; v.exc = ex;
    v.e_err = ee; v.e_busy = eb; v.e_go = eg;
    v.lit = 1'b0; v.i0 = '0; v.i1 = '0; v.i2 = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input cmd_t c);
    bus.cmd_cmdtype  = c.cmdtype;
    bus.cmd_transfer = c.transfer;
    bus.cmd_write    = c.write;
    bus.cmd_postexec = c.postexec;
    bus.cmd_aarsize  = c.aarsize;
    bus.cmd_regno    = c.regno;
    bus.hart_halted  = c.halted;
    bus.cmd_wr_en    = 1'b1;
  endtask

  // Hart pulses follow a fixed schedule counted from the command write.
  task automatic run_cmd(input cmd_t c, input int d_go, input int d_done, input bit exc,
                         input int e_err, input int e_busy, input int e_go);
    drive_cmd(c);
    for (int k = 1; k <= WIN; k++) begin
      tick();
      bus.cmd_wr_en      = 1'b0;
      bus.hart_going     = (k == 2 + d_go);
      bus.hart_done      = (k == 3 + d_go + d_done);
      bus.hart_exception = exc && (k == 3 + d_go + d_done);
      bus.absbuf_idx     = 2'(k % 4);
      #1;
      check($sformatf("busy k=%0d", k), 32'(bus.busy), 32'(k <= e_busy));
      check($sformatf("hart_go k=%0d", k), 32'(bus.hart_go), 32'(k >= 2 && k < 2 + e_go));
      if (k <= e_busy)
        check($sformatf("absbuf idx=%0d", k % 4), bus.absbuf_rdata, exp_buf(c, k % 4));
    end
    bus.hart_going = 1'b0; bus.hart_done = 1'b0; bus.hart_exception = 1'b0;
    check("cmderr", 32'(bus.cmderr), 32'(e_err));
    bus.cmderr_clr = 3'b111;
    tick();
    bus.cmderr_clr = 3'b000;
    check("cmderr after clear", 32'(bus.cmderr), 32'd0);
  endtask

  vec_t tv[12];

  initial begin
    cmd_t c;
    int   dg, dd, ee, eb, eg;
    bit   ex;

    tv[0]  = mk(8'd0, 1, 1, 0, 3'd2, 16'h1005, 1, 0, 1, 0, 0, 4, 1);
    tv[0].lit = 1'b1; tv[0].i0 = 32'h4000_2283; tv[0].i1 = NOP; tv[0].i2 = EBREAK;
    tv[1]  = mk(8'd0, 1, 0, 1, 3'd2, 16'h0341, 1, 1, 2, 0, 0, 6, 2);
    tv[1].lit = 1'b1; tv[1].i0 = 32'h3410_2473; tv[1].i1 = 32'h4080_2023; tv[1].i2 = JAL;
    tv[2]  = mk(8'd2, 1, 0, 0, 3'd2, 16'h1001, 1, 0, 0, 0, 2, 1, 0);
    tv[3]  = mk(8'd0, 1, 0, 0, 3'd3, 16'h1001, 1, 0, 0, 0, 2, 1, 0);
    tv[4]  = mk(8'd0, 1, 0, 0, 3'd2, 16'h1001, 0, 0, 0, 0, 4, 1, 0);
    tv[5]  = mk(8'd0, 1, 0, 0, 3'd2, 16'h2000, 1, 0, 0, 0, 2, 1, 0);
    tv[6]  = mk(8'd0, 0, 0, 0, 3'd3, 16'hf000, 1, 0, 0, 0, 0, 1, 0);
    tv[7]  = mk(8'd0, 0, 0, 1, 3'd3, 16'hf000, 1, 2, 0, 0, 0, 5, 3);
    tv[8]  = mk(8'd0, 1, 1, 0, 3'd2, 16'h1002, 1, 0, 0, 1, 3, 3, 1);
    tv[9]  = mk(8'd0, 1, 0, 0, 3'd2, 16'h1002, 1, 100, 0, 0, 7, 17, 16);
    tv[10] = mk(8'd0, 1, 0, 0, 3'd2, 16'h1002, 1, 5, 9, 0, 0, 17, 6);
    tv[11] = mk(8'd0, 1, 0, 0, 3'd2, 16'h1002, 1, 5, 10, 0, 7, 17, 6);

    rst = 1'b1;
    bus.cmd_wr_en = 1'b0; bus.cmd_cmdtype = '0; bus.cmd_transfer = 1'b0; bus.cmd_write = 1'b0;
    bus.cmd_postexec = 1'b0; bus.cmd_aarsize = '0; bus.cmd_regno = '0; bus.cmderr_clr = '0;
    bus.hart_halted = 1'b0; bus.absbuf_idx = '0;
    bus.hart_going = 1'b0; bus.hart_done = 1'b0; bus.hart_exception = 1'b0;
    repeat (3) tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset hart_go", 32'(bus.hart_go), 32'd0);
    check("reset cmderr", 32'(bus.cmderr), 32'd0);
    check("reset q_regno", 32'(bus.q_regno), 32'd0);
    check("reset q_cmdtype", 32'(bus.q_cmdtype), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_cmd(tv[i].c, tv[i].d_go, tv[i].d_done, tv[i].exc, tv[i].e_err, tv[i].e_busy, tv[i].e_go);
      if (tv[i].lit) begin
        bus.absbuf_idx = 2'd0; #1; check($sformatf("vec%0d idx0", i), bus.absbuf_rdata, tv[i].i0);
        bus.absbuf_idx = 2'd1; #1; check($sformatf("vec%0d idx1", i), bus.absbuf_rdata, tv[i].i1);
        bus.absbuf_idx = 2'd2; #1; check($sformatf("vec%0d idx2", i), bus.absbuf_rdata, tv[i].i2);
      end
    end

    // Write while busy: flagged, running command finishes, q_* untouched.
    c = '{8'd0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h1003, 1'b1};
    drive_cmd(c);
    tick(); bus.cmd_wr_en = 1'b0;
    tick(); bus.hart_going = 1'b1;
    tick(); bus.hart_going = 1'b0;
    bus.cmd_regno = 16'h1007; bus.cmd_write = 1'b1; bus.cmd_wr_en = 1'b1;
    tick(); bus.cmd_wr_en = 1'b0;
    check("wr busy cmderr", 32'(bus.cmderr), 32'd1);
    check("wr busy still busy", 32'(bus.busy), 32'd1);
    bus.hart_done = 1'b1;
    tick(); bus.hart_done = 1'b0;
    check("wr busy done idle", 32'(bus.busy), 32'd0);
    check("wr busy q_regno", 32'(bus.q_regno), 32'h1003);
    check("wr busy q_write", 32'(bus.q_write), 32'd0);

    // Sticky error blocks a new write until cleared.
    bus.cmd_regno = 16'h1009; bus.cmd_wr_en = 1'b1;
    tick(); bus.cmd_wr_en = 1'b0;
    check("ignored write busy", 32'(bus.busy), 32'd0);
    check("ignored write q_regno", 32'(bus.q_regno), 32'h1003);
    bus.cmderr_clr = 3'b111;
    tick(); bus.cmderr_clr = 3'b000;
    check("clear cmderr", 32'(bus.cmderr), 32'd0);

    // Accepted write, then reset mid-EXEC with a pending error.
    c = '{8'd0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h1009, 1'b1};
    drive_cmd(c);
    tick(); bus.cmd_wr_en = 1'b0;
    check("accept busy", 32'(bus.busy), 32'd1);
    check("accept q_regno", 32'(bus.q_regno), 32'h1009);
    tick(); bus.hart_going = 1'b1;
    tick(); bus.hart_going = 1'b0; bus.cmd_wr_en = 1'b1;
    tick(); bus.cmd_wr_en = 1'b0;
    bus.absbuf_idx = 2'd2; #1;
    check("pre-reset cmderr", 32'(bus.cmderr), 32'd1);
    check("pre-reset idx2", bus.absbuf_rdata, JAL);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset hart_go", 32'(bus.hart_go), 32'd0);
    check("mid reset cmderr", 32'(bus.cmderr), 32'd0);
    check("mid reset q_regno", 32'(bus.q_regno), 32'd0);
    check("mid reset q_write", 32'(bus.q_write), 32'd0);
    check("mid reset q_transfer", 32'(bus.q_transfer), 32'd0);
    check("mid reset q_aarsize", 32'(bus.q_aarsize), 32'd0);
    check("mid reset idx2", bus.absbuf_rdata, EBREAK);
    tick();

    for (int n = 0; n < 40; n++) begin
      c.cmdtype  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      c.transfer = 1'($urandom_range(0, 1));
      c.write    = 1'($urandom_range(0, 1));
      c.postexec = 1'($urandom_range(0, 1));
      c.aarsize  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      c.regno    = {(($urandom_range(0, 4) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1))),
                    12'($urandom)};
      c.halted   = ($urandom_range(0, 7) != 0);
      dg = $urandom_range(0, 10);
      dd = $urandom_range(0, 10);
      ex = ($urandom_range(0, 4) == 0);
      model(c, dg, dd, ex, ee, eb, eg);
      run_cmd(c, dg, dd, ex, ee, eb, eg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
